reg_file_ctrl: RTL and testbench
================================

# reg_file_ctrl

Write-port controller for the 32x32 register file. It runs a power-up sequence that clears every register to zero, then arbitrates the single write port between two writeback requesters. Requester A is the in-order pipeline writeback; requester B is the long-latency unit (load/multi-cycle ops). The block sits between those sources and the register file's `regWrite`/`rd`/`writeData` inputs; read ports are untouched.

## Interface
Parameters:
- `NUM_REGS`, 32, registers cleared during init; also the highest address + 1
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, number of consecutive cycles B may lose arbitration before it wins over A

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-high
- `aValid`  in  1  A write request
- `aRd`  in  ADDR_W  A destination
- `aData`  in  DATA_W  A write data
- `aReady`  out  1  A accepted this cycle when `aValid & aReady`
- `bValid`, `bRd`, `bData`, `bReady`  same as A, for requester B
- `regWrite`  out  1  register-file write enable (registered)
- `rd`  out  ADDR_W  register-file write address (registered)
- `writeData`  out  DATA_W  register-file write data (registered)
- `initBusy`  out  1  high while the clear sequence runs

## Operation
- States: INIT, RUN. Reset forces INIT with `initCnt=0`, `starveCnt=0`, `regWrite=0`, `rd=0`, `writeData=0`. `initBusy` is 1 (state==INIT). `aReady` and `bReady` are 0.
- INIT:
  - Each posedge loads `{regWrite,rd,writeData} <= {1, initCnt, 0}` and increments `initCnt`.
  - On the edge that loads `rd=NUM_REGS-1`, the state becomes RUN.
  - Requests are never accepted in INIT.
- RUN, x0 requests:
  - A request with `Rd==0` is always ready and is accepted.
  - It is discarded: it never produces `regWrite` and never consumes the port.
- RUN, nonzero requests: at most one is granted per cycle.
  - `bWins = bValid & bRd!=0 & starveCnt==STARVE_LIMIT`.
  - `aReady = RUN & (aRd==0 | !bWins)`.
  - `bReady = RUN & (bRd==0 | bWins | !(aValid & aRd!=0))`.
  - Ready may depend on the other requester's valid. Valid must never depend on ready.
- Starvation counter:
  - `starveCnt` increments, saturating at STARVE_LIMIT, each cycle that B has a nonzero request pending and is not granted.
  - It clears on a B grant, or when B has no nonzero request.
- Grant output:
  - A nonzero grant loads `{1, Rd, Data}` into the outputs on the same edge.
  - With no grant, `regWrite <= 0`, and `rd`/`writeData` hold their values.
- Same `Rd` requested by A and B in one cycle: the winner writes first and the loser waits. No merging or reordering is performed.
- Reset mid-operation:
  - Any write held in the output registers is dropped asynchronously.
  - Any pending request is not accepted.
  - The full clear sequence restarts.

## Timing
- After reset release, edges 1..NUM_REGS present `rd = 0..NUM_REGS-1` with `regWrite=1`, `writeData=0`.
- After edge NUM_REGS, `initBusy=0`. The earliest acceptance is edge NUM_REGS+1.
- Accept-to-write latency: a request accepted at edge k appears on `regWrite`/`rd`/`writeData` after edge k. The register file captures it at edge k+1.
- Throughput: one nonzero write per cycle, plus any number of x0 discards.
- B worst-case wait with A saturating: STARVE_LIMIT cycles, then B is granted on the next cycle.

## Test plan
- Reset then idle:
  - `initBusy=1` for 32 edges; `rd` steps 0..31 with `regWrite=1`, `writeData=0`.
  - Afterwards `regWrite=0`, and register-file reads of x5 and x31 return 0.
- RUN, A alone (`aRd=3`, `aData=0xDEADBEEF`): `aReady=1`; one cycle later `regWrite=1`, `rd=3`; the read of x3 returns 0xDEADBEEF on the following cycle.
- A and B both valid every cycle, rd 7/9:
  - A is granted 4 cycles, then B is granted once, with `starveCnt` returning to 0.
  - This pattern repeats: A,A,A,A,B.
- `aRd=0` and `bRd=12` valid together: both are accepted in one cycle. Only `rd=12` is written; x0 still reads 0.
- Reset asserted mid-INIT (at `rd=17`) and again in RUN with a write held on the outputs:
  - `regWrite` drops to 0 immediately.
  - The sequence restarts at `rd=0`.
  - The held write never reaches the register file.
- Requests during INIT (`aValid=1`): `aReady` stays 0 until RUN, and the request is accepted on the first RUN cycle.

Source files
------------

// File: rtl/reg_file_ctrl_if.sv
// -----------------------------------------------------------------------------
// reg_file_ctrl_if
// Bundle of the write-port controller's bus signals: two writeback requesters
// (A = in-order pipeline, B = long-latency unit) and the register-file write
// port driven by the controller.
//
// Signals:
//   aValid/aRd/aData   requester A write request, destination, data
//   aReady             A accepted this cycle when aValid & aReady
//   bValid/bRd/bData   requester B write request, destination, data
//   bReady             B accepted this cycle when bValid & bReady
//   regWrite/rd/writeData  registered register-file write port
//   initBusy           high while the power-up clear sequence runs
//
// Modports:
//   master  requesters + register file side (drives requests)
//   slave   the controller (drives ready, write port, initBusy)
// -----------------------------------------------------------------------------
interface reg_file_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              aValid;
    logic [ADDR_W-1:0] aRd;
    logic [DATA_W-1:0] aData;
    logic              aReady;

    logic              bValid;
    logic [ADDR_W-1:0] bRd;
    logic [DATA_W-1:0] bData;
    logic              bReady;

    logic              regWrite;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] writeData;
    logic              initBusy;

    modport master (
        output aValid, aRd, aData,
        output bValid, bRd, bData,
        input  aReady, bReady,
        input  regWrite, rd, writeData, initBusy
    );

    modport slave (
        input  aValid, aRd, aData,
        input  bValid, bRd, bData,
        output aReady, bReady,
        output regWrite, rd, writeData, initBusy
    );
endinterface

// File: rtl/reg_file_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_ctrl
// Write-port controller for the register file. After reset it walks every
// register address writing zero (INIT), then arbitrates the single write port
// between requester A (pipeline writeback) and requester B (long-latency unit)
// (RUN). A wins by default; B wins once it has lost STARVE_LIMIT consecutive
// cycles. Requests targeting x0 are accepted and silently discarded.
//
// Ports:
//   clk    in   single clock, all state on posedge
//   reset  in   asynchronous, active-high; restarts the clear sequence
//   bus    slave modport of reg_file_ctrl_if (requests, readies, write port)
// -----------------------------------------------------------------------------
module reg_file_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    reg_file_ctrl_if.slave  bus
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0]   LAST_REG   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   init_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic                reg_write_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]   write_data_q;

    logic run_s;
    logic a_nz_s;
    logic b_nz_s;
    logic b_wins_s;
    logic a_ready_s;
    logic b_ready_s;
    logic a_grant_s;
    logic b_grant_s;

    // Arbitration: x0 requests are always ready; a nonzero B beats A only
    // once its starvation counter has saturated.
    always_comb begin
        run_s     = (state_q == ST_RUN);
        a_nz_s    = bus.aValid && (bus.aRd != '0);
        b_nz_s    = bus.bValid && (bus.bRd != '0);
        b_wins_s  = b_nz_s && (starve_cnt_q == STARVE_MAX);
        a_ready_s = run_s && ((bus.aRd == '0) || !b_wins_s);
        b_ready_s = run_s && ((bus.bRd == '0) || b_wins_s || !a_nz_s);
        // Only nonzero accepted requests consume the write port.
        a_grant_s = a_nz_s && a_ready_s;
        b_grant_s = b_nz_s && b_ready_s;
    end

    // Starvation count: counts cycles a nonzero B request is left waiting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (b_grant_s || !b_nz_s) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Controller FSM: clear sequence, then one granted write per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            starve_cnt_q <= '0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            write_data_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    reg_write_q  <= 1'b1;
                    rd_q         <= init_cnt_q;
                    write_data_q <= '0;
                    init_cnt_q   <= init_cnt_q + 1'b1;
                    starve_cnt_q <= '0;
                    // Leave INIT on the edge that issues the last clear.
                    if (init_cnt_q == LAST_REG) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_INIT;
                    end
                end
                ST_RUN: begin
                    starve_cnt_q <= starve_cnt_d;
                    if (a_grant_s) begin
                        reg_write_q  <= 1'b1;
                        rd_q         <= bus.aRd;
                        write_data_q <= bus.aData;
                    end else if (b_grant_s) begin
                        reg_write_q  <= 1'b1;
                        rd_q         <= bus.bRd;
                        write_data_q <= bus.bData;
                    end else begin
                        // Address/data hold; only the enable drops.
                        reg_write_q  <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover through a full clear.
                    state_q      <= ST_INIT;
                    init_cnt_q   <= '0;
                    starve_cnt_q <= '0;
                    reg_write_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.aReady    = a_ready_s;
    assign bus.bReady    = b_ready_s;
    assign bus.regWrite  = reg_write_q;
    assign bus.rd        = rd_q;
    assign bus.writeData = write_data_q;
    assign bus.initBusy  = (state_q == ST_INIT);

endmodule

// File: tb/tb_reg_file_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_file_ctrl
// Scoreboard bench for reg_file_ctrl: every write the controller is expected
// to issue is queued when stimulus is driven; each regWrite pulse pops and
// compares. A behavioural register file captures writes for read-back checks.
// -----------------------------------------------------------------------------
module tb_reg_file_ctrl;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    reg_file_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_file_ctrl #(
        .NUM_REGS     (NUM_REGS),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0]        rf [NUM_REGS];
    logic [ADDR_W+DATA_W-1:0] exp_q [$];

    // Single comparison point: counts, and reports any mismatch.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard and register-file model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && bus.regWrite === 1'b1) begin
            logic [ADDR_W+DATA_W-1:0] exp_word;
            check_val("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                check_val("sb_write", 64'({bus.rd, bus.writeData}), 64'(exp_word));
            end
            rf[bus.rd] <= bus.writeData;
        end
    end

    // Run-time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic release_reset();
        reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_q.push_back({ADDR_W'(i), DATA_W'(0)});
        end
    endtask

    // Walk the clear sequence, optionally with A requesting x20 throughout.
    task automatic do_init(input bit with_req);
        if (with_req) begin
            bus.aValid = 1'b1;
            bus.aRd    = 5'd20;
            bus.aData  = 32'hCAFE_F00D;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            check_val("init_busy", 64'(bus.initBusy), 64'd1);
            check_val("init_a_ready", 64'(bus.aReady), 64'd0);
            @(posedge clk); #1;
        end
        check_val("run_busy", 64'(bus.initBusy), 64'd0);
        check_val("run_a_ready", 64'(bus.aReady), 64'd1);
        if (with_req) begin
            exp_q.push_back({5'd20, 32'hCAFE_F00D});
        end
        @(posedge clk); #1;
        bus.aValid = 1'b0;
        @(posedge clk); #1;
        check_val("run_idle_wr", 64'(bus.regWrite), 64'd0);
    endtask

    initial begin
        int a_seq;
        int b_seq;
        bit b_turn;

        for (int i = 0; i < NUM_REGS; i++) begin
            rf[i] = 32'hA5A5_0000 | DATA_W'(i);
        end
        bus.aValid = 1'b0; bus.aRd = '0; bus.aData = '0;
        bus.bValid = 1'b0; bus.bRd = '0; bus.bData = '0;

        // Reset state.
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_wr", 64'(bus.regWrite), 64'd0);
        check_val("rst_rd", 64'(bus.rd), 64'd0);
        check_val("rst_busy", 64'(bus.initBusy), 64'd1);
        check_val("rst_a_ready", 64'(bus.aReady), 64'd0);

        // Clear sequence then idle.
        release_reset();
        do_init(1'b0);
        check_val("rf_x5", 64'(rf[5]), 64'd0);
        check_val("rf_x31", 64'(rf[31]), 64'd0);

        // A alone.
        bus.aValid = 1'b1; bus.aRd = 5'd3; bus.aData = 32'hDEAD_BEEF;
        #1;
        check_val("a_only_ready", 64'(bus.aReady), 64'd1);
        exp_q.push_back({5'd3, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        bus.aValid = 1'b0;
        check_val("a_only_wr", 64'(bus.regWrite), 64'd1);
        check_val("a_only_rd", 64'(bus.rd), 64'd3);
        @(posedge clk); #1;
        check_val("rf_x3", 64'(rf[3]), 64'hDEAD_BEEF);

        // A and B contending every cycle: expect A,A,A,A,B repeating.
        a_seq = 0;
        b_seq = 0;
        for (int c = 0; c < 10; c++) begin
            bus.aValid = 1'b1; bus.aRd = 5'd7; bus.aData = 32'hA000_0000 + DATA_W'(a_seq);
            bus.bValid = 1'b1; bus.bRd = 5'd9; bus.bData = 32'hB000_0000 + DATA_W'(b_seq);
            #1;
            b_turn = ((c % 5) == 4);
            check_val("arb_a_ready", 64'(bus.aReady), 64'(!b_turn));
            check_val("arb_b_ready", 64'(bus.bReady), 64'(b_turn));
            if (b_turn) begin
                exp_q.push_back({5'd9, 32'hB000_0000 + DATA_W'(b_seq)});
                b_seq++;
            end else begin
                exp_q.push_back({5'd7, 32'hA000_0000 + DATA_W'(a_seq)});
                a_seq++;
            end
            @(posedge clk); #1;
        end
        bus.aValid = 1'b0;
        bus.bValid = 1'b0;
        @(posedge clk); #1;
        check_val("rf_x7", 64'(rf[7]), 64'hA000_0007);
        check_val("rf_x9", 64'(rf[9]), 64'hB000_0001);

        // A to x0 together with B: both accepted, only B writes.
        bus.aValid = 1'b1; bus.aRd = 5'd0;  bus.aData = 32'hFFFF_FFFF;
        bus.bValid = 1'b1; bus.bRd = 5'd12; bus.bData = 32'h1212_1212;
        #1;
        check_val("x0a_a_ready", 64'(bus.aReady), 64'd1);
        check_val("x0a_b_ready", 64'(bus.bReady), 64'd1);
        exp_q.push_back({5'd12, 32'h1212_1212});
        @(posedge clk); #1;
        // B to x0 together with A: both accepted, only A writes.
        bus.aRd = 5'd5;  bus.aData = 32'h5555_5555;
        bus.bRd = 5'd0;  bus.bData = 32'hFFFF_FFFF;
        #1;
        check_val("x0b_a_ready", 64'(bus.aReady), 64'd1);
        check_val("x0b_b_ready", 64'(bus.bReady), 64'd1);
        exp_q.push_back({5'd5, 32'h5555_5555});
        @(posedge clk); #1;
        bus.aValid = 1'b0;
        bus.bValid = 1'b0;
        @(posedge clk); #1;
        check_val("rf_x12", 64'(rf[12]), 64'h1212_1212);
        check_val("rf_x5_w", 64'(rf[5]), 64'h5555_5555);
        check_val("rf_x0", 64'(rf[0]), 64'd0);

        // Reset in RUN with a write held on the outputs.
        bus.aValid = 1'b1; bus.aRd = 5'd4; bus.aData = 32'h4444_4444;
        exp_q.push_back({5'd4, 32'h4444_4444});
        @(posedge clk); #1;
        bus.aValid = 1'b0;
        check_val("held_wr", 64'(bus.regWrite), 64'd1);
        check_val("held_rd", 64'(bus.rd), 64'd4);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_val("rst_run_wr", 64'(bus.regWrite), 64'd0);
        check_val("rst_run_data", 64'(bus.writeData), 64'd0);
        check_val("rst_run_busy", 64'(bus.initBusy), 64'd1);
        @(posedge clk); #1;
        check_val("rf_x4_dropped", 64'(rf[4]), 64'd0);
        release_reset();
        do_init(1'b0);

        // Reset mid-INIT at rd=17, then re-init with A requesting throughout.
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        release_reset();
        repeat (18) @(posedge clk);
        #1;
        check_val("mid_init_rd", 64'(bus.rd), 64'd17);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_val("mid_init_wr", 64'(bus.regWrite), 64'd0);
        check_val("mid_init_rd0", 64'(bus.rd), 64'd0);
        @(posedge clk); #1;
        release_reset();
        do_init(1'b1);
        check_val("rf_x20", 64'(rf[20]), 64'hCAFE_F00D);

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
